// File: rtl/cu_pkg.sv
// Shared types and encodings for the multi-cycle RV32 control unit.
// Optional build macro: CU_ILLEGAL_TRAP_EN (illegal instructions park the FSM in TRAP).
package cu_pkg;

    localparam int unsigned ALUOP_W = 2;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] F3_000 = 3'b000;
    localparam logic [2:0] F3_001 = 3'b001;
    localparam logic [2:0] F3_010 = 3'b010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_BR    = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_R    = 3'd0,
        CL_IALU = 3'd1,
        CL_LD   = 3'd2,
        CL_ST   = 3'd3,
        CL_BR   = 3'd4,
        CL_JAL  = 3'd5,
        CL_JALR = 3'd6,
        CL_ILL  = 3'd7
    } insn_class_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle; master is the control unit side.
interface multicycle_control_unit_if #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned ALUOP_W = 2
);
    logic [31:0]        instruction;
    logic               mem_ready;
    logic               branch_taken;
    logic               imem_req;
    logic               dmem_req;
    logic               ir_write;
    logic               pc_write;
    logic               MemRead;
    logic               MemWrite;
    logic               MemToReg;
    logic               ALUSrc;
    logic               RegWrite;
    logic               branch;
    logic               jal_sel;
    logic               jalr_sel;
    logic [ALUOP_W-1:0] ALUOp;
    logic [2:0]         phase;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   instret_cnt;
    logic               illegal_insn;

    modport master (
        input  instruction, mem_ready, branch_taken,
        output imem_req, dmem_req, ir_write, pc_write, MemRead, MemWrite, MemToReg,
               ALUSrc, RegWrite, branch, jal_sel, jalr_sel, ALUOp, phase,
               cycle_cnt, instret_cnt, illegal_insn
    );

    modport slave (
        output instruction, mem_ready, branch_taken,
        input  imem_req, dmem_req, ir_write, pc_write, MemRead, MemWrite, MemToReg,
               ALUSrc, RegWrite, branch, jal_sel, jalr_sel, ALUOp, phase,
               cycle_cnt, instret_cnt, illegal_insn
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational instruction classifier: {funct3, opcode} -> instruction class.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [6:0]  opcode,
    output insn_class_t cls
);

    always_comb begin
        cls = CL_ILL;
        case (opcode)
            OP_R:    if (funct3[2:1] != 2'b01) cls = CL_R;
            OP_IALU: if (funct3 == F3_000 || funct3 == F3_001) cls = CL_IALU;
            OP_LD:   if (funct3 == F3_010) cls = CL_LD;
            OP_ST:   if (funct3 == F3_010) cls = CL_ST;
            OP_BR:   if (!funct3[1]) cls = CL_BR;
            OP_JAL:  cls = CL_JAL;
            OP_JALR: if (funct3 == F3_000) cls = CL_JALR;
            default: cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM with memory handshake and cycle/instret counters.
// Optional build macro: CU_ILLEGAL_TRAP_EN (illegal instructions enter a sticky TRAP state).
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned ALUOP_W = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
);

    state_t            state;
    insn_class_t       cls;
    insn_class_t       dec_cls;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instret_q;
    logic              retire;
    logic              unused_insn_bits;

    logic               imem_req, dmem_req, ir_write, pc_write;
    logic               mem_read, mem_write, mem_to_reg, alu_src, reg_write;
    logic               branch, jal_sel, jalr_sel, illegal;
    logic [ALUOP_W-1:0] alu_op;

    assign unused_insn_bits = ^{bus.instruction[31:15], bus.instruction[11:7], bus.branch_taken};

    cu_decoder u_dec (
        .funct3 (bus.instruction[14:12]),
        .opcode (bus.instruction[6:0]),
        .cls    (dec_cls)
    );

    // State, latched class and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            cls       <= CL_ILL;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (retire) instret_q <= instret_q + CNT_W'(1);
            case (state)
                ST_FETCH: begin
                    if (bus.mem_ready) begin
                        cls   <= dec_cls;
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
`ifdef CU_ILLEGAL_TRAP_EN
                    state <= (cls == CL_ILL) ? ST_TRAP : ST_EXEC;
`else
                    state <= (cls == CL_ILL) ? ST_FETCH : ST_EXEC;
`endif
                end
                ST_EXEC: begin
                    case (cls)
                        CL_R, CL_IALU: state <= ST_WB;
                        CL_LD, CL_ST:  state <= ST_MEM;
                        default:       state <= ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    if (bus.mem_ready) state <= (cls == CL_LD) ? ST_WB : ST_FETCH;
                end
                ST_WB:   state <= ST_FETCH;
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Moore control decode; FETCH outputs are forced low while reset is asserted.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        jal_sel    = 1'b0;
        jalr_sel   = 1'b0;
        illegal    = 1'b0;
        alu_op     = ALUOP_W'(ALUOP_ADD);
        case (state)
            ST_FETCH: begin
                imem_req = rst_n;
                ir_write = rst_n & bus.mem_ready;
            end
            ST_DECODE: begin
`ifndef CU_ILLEGAL_TRAP_EN
                pc_write = (cls == CL_ILL);
`endif
            end
            ST_EXEC: begin
                case (cls)
                    CL_R:    alu_op = ALUOP_W'(ALUOP_FUNCT);
                    CL_IALU: begin alu_op = ALUOP_W'(ALUOP_FUNCT); alu_src = 1'b1; end
                    CL_LD, CL_ST: alu_src = 1'b1;
                    CL_BR:   begin alu_op = ALUOP_W'(ALUOP_BR); branch = 1'b1; pc_write = 1'b1; end
                    CL_JAL:  begin reg_write = 1'b1; jal_sel = 1'b1; pc_write = 1'b1; end
                    CL_JALR: begin alu_src = 1'b1; reg_write = 1'b1; jalr_sel = 1'b1; pc_write = 1'b1; end
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (cls == CL_LD);
                mem_write = (cls == CL_ST);
                pc_write  = (cls == CL_ST);
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cls == CL_LD);
                pc_write   = 1'b1;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            ST_TRAP: illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    // A store's pc_write spans the whole MEM wait but retires once, on completion.
    always_comb begin
        retire = pc_write && (state != ST_DECODE) && !(state == ST_MEM && !bus.mem_ready);
    end

    assign bus.imem_req     = imem_req;
    assign bus.dmem_req     = dmem_req;
    assign bus.ir_write     = ir_write;
    assign bus.pc_write     = pc_write;
    assign bus.MemRead      = mem_read;
    assign bus.MemWrite     = mem_write;
    assign bus.MemToReg     = mem_to_reg;
    assign bus.ALUSrc       = alu_src;
    assign bus.RegWrite     = reg_write;
    assign bus.branch       = branch;
    assign bus.jal_sel      = jal_sel;
    assign bus.jalr_sel     = jalr_sel;
    assign bus.ALUOp        = alu_op;
    assign bus.phase        = 3'(state);
    assign bus.cycle_cnt    = cycle_q;
    assign bus.instret_cnt  = instret_q;
    assign bus.illegal_insn = illegal;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench: per-instruction phase scripts from the class rules, checked every cycle.
module tb_multicycle_control_unit;

    localparam logic [2:0] P_F = 3'd0, P_D = 3'd1, P_E = 3'd2, P_M = 3'd3, P_W = 3'd4, P_T = 3'd5;
    localparam int K_R = 0, K_IALU = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_JAL = 5, K_JALR = 6, K_ILL = 7;

    typedef struct packed {
        logic imem_req, dmem_req, ir_write, pc_write;
        logic mem_read, mem_write, mem_to_reg, alu_src, reg_write;
        logic branch, jal_sel, jalr_sel;
        logic [1:0] alu_op;
        logic illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        branch_taken;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.CNT_W(32), .ALUOP_W(2)) bus ();
    multicycle_control_unit_if #(.CNT_W(4),  .ALUOP_W(2)) bus4 ();

    assign bus.instruction   = instruction;
    assign bus.mem_ready     = mem_ready;
    assign bus.branch_taken  = branch_taken;
    assign bus4.instruction  = instruction;
    assign bus4.mem_ready    = mem_ready;
    assign bus4.branch_taken = branch_taken;

    multicycle_control_unit #(.CNT_W(32), .ALUOP_W(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    multicycle_control_unit #(.CNT_W(4),  .ALUOP_W(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    ctl_t act, act4;
    assign act  = {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.MemRead, bus.MemWrite,
                   bus.MemToReg, bus.ALUSrc, bus.RegWrite, bus.branch, bus.jal_sel, bus.jalr_sel,
                   bus.ALUOp, bus.illegal_insn};
    assign act4 = {bus4.imem_req, bus4.dmem_req, bus4.ir_write, bus4.pc_write, bus4.MemRead, bus4.MemWrite,
                   bus4.MemToReg, bus4.ALUSrc, bus4.RegWrite, bus4.branch, bus4.jal_sel, bus4.jalr_sel,
                   bus4.ALUOp, bus4.illegal_insn};

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned inst = 0;
    ctl_t        exp_ctl;
    logic [2:0]  exp_ph;
    logic        exp_valid = 1'b0;

    logic [2:0] r_f3  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [2:0] br_f3 [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        if (op == 7'b0110011 && f3 != 3'd2 && f3 != 3'd3) return K_R;
        if (op == 7'b0010011 && f3 <= 3'd1) return K_IALU;
        if (op == 7'b0000011 && f3 == 3'd2) return K_LD;
        if (op == 7'b0100011 && f3 == 3'd2) return K_ST;
        if (op == 7'b1100011 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)) return K_BR;
        if (op == 7'b1101111) return K_JAL;
        if (op == 7'b1100111 && f3 == 3'd0) return K_JALR;
        return K_ILL;
    endfunction

    function automatic ctl_t ctl_of(input logic [2:0] ph, input int k, input logic rdy);
        ctl_t c;
        c = '0;
        case (ph)
            P_F: begin c.imem_req = 1'b1; c.ir_write = rdy; end
            P_D: begin
`ifndef CU_ILLEGAL_TRAP_EN
                c.pc_write = (k == K_ILL);
`endif
            end
            P_E: begin
                if (k == K_R)    c.alu_op = 2'b10;
                if (k == K_IALU) begin c.alu_op = 2'b10; c.alu_src = 1'b1; end
                if (k == K_LD || k == K_ST) c.alu_src = 1'b1;
                if (k == K_BR)   begin c.alu_op = 2'b01; c.branch = 1'b1; c.pc_write = 1'b1; end
                if (k == K_JAL)  begin c.reg_write = 1'b1; c.jal_sel = 1'b1; c.pc_write = 1'b1; end
                if (k == K_JALR) begin c.alu_src = 1'b1; c.reg_write = 1'b1; c.jalr_sel = 1'b1; c.pc_write = 1'b1; end
            end
            P_M: begin
                c.dmem_req = 1'b1; c.mem_read = (k == K_LD);
                c.mem_write = (k == K_ST); c.pc_write = (k == K_ST);
            end
            P_W: begin c.reg_write = 1'b1; c.mem_to_reg = (k == K_LD); c.pc_write = 1'b1; end
            P_T: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] gen_word(input int k);
        logic [31:0] w;
        w = $urandom;
        case (k)
            K_R:    begin w[6:0] = 7'b0110011; w[14:12] = r_f3[$urandom_range(0, 5)]; end
            K_IALU: begin w[6:0] = 7'b0010011; w[14:12] = 3'($urandom_range(0, 1)); end
            K_LD:   begin w[6:0] = 7'b0000011; w[14:12] = 3'd2; end
            K_ST:   begin w[6:0] = 7'b0100011; w[14:12] = 3'd2; end
            K_BR:   begin w[6:0] = 7'b1100011; w[14:12] = br_f3[$urandom_range(0, 3)]; end
            K_JAL:  w[6:0] = 7'b1101111;
            K_JALR: begin w[6:0] = 7'b1100111; w[14:12] = 3'd0; end
            default: begin
                // near-miss encodings: legal opcode with a funct3 outside its class
                case ($urandom_range(0, 3))
                    0: begin w[6:0] = 7'b0110011; w[14:12] = 3'($urandom_range(2, 3)); end
                    1: begin w[6:0] = 7'b1100011; w[14:12] = 3'($urandom_range(2, 3)); end
                    2: begin w[6:0] = 7'b1100111; w[14:12] = 3'($urandom_range(1, 7)); end
                    default: ;
                endcase
            end
        endcase
        return w;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            check("ctl",        64'(act),             64'(exp_ctl));
            check("ctl4",       64'(act4),            64'(exp_ctl));
            check("phase",      64'(bus.phase),       64'(exp_ph));
            check("cycle_cnt",  64'(bus.cycle_cnt),   64'(cyc));
            check("instret",    64'(bus.instret_cnt), 64'(inst));
            check("cycle_cnt4", 64'(bus4.cycle_cnt),  64'(cyc % 16));
            check("instret4",   64'(bus4.instret_cnt), 64'(inst % 16));
        end
    end

    task automatic step(input logic rdy, input logic [31:0] ins, input logic [2:0] ph,
                        input int k, input logic ret);
        mem_ready    = rdy;
        instruction  = ins;
        branch_taken = 1'($urandom);
        exp_ph       = ph;
        exp_ctl      = ctl_of(ph, k, rdy);
        exp_valid    = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        if (ret) inst++;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_ctl",      64'(act),              64'd0);
        check("rst_phase",    64'(bus.phase),        64'd0);
        check("rst_cycle",    64'(bus.cycle_cnt),    64'd0);
        check("rst_instret",  64'(bus.instret_cnt),  64'd0);
        check("rst_cycle4",   64'(bus4.cycle_cnt),   64'd0);
        @(posedge clk);
        #1;
        check("rst_hold_ctl", 64'(act),              64'd0);
        rst_n = 1'b1;
        cyc = 0;
        inst = 0;
    endtask

    task automatic run_insn(input logic [31:0] w, input int fw, input int mw, input int rst_at);
        int k;
        k = classify(w);
        for (int i = 0; i < fw; i++) step(1'b0, $urandom, P_F, k, 1'b0);
        step(1'b1, w, P_F, k, 1'b0);
        step(1'($urandom), $urandom, P_D, k, 1'b0);
        if (k == K_ILL) begin
`ifdef CU_ILLEGAL_TRAP_EN
            for (int i = 0; i < 20; i++) step(1'($urandom), $urandom, P_T, k, 1'b0);
            check("trap_sticky", 64'(bus.illegal_insn), 64'd1);
            do_reset();
`endif
            return;
        end
        step(1'($urandom), $urandom, P_E, k, 1'(k == K_BR || k == K_JAL || k == K_JALR));
        if (k == K_LD || k == K_ST) begin
            for (int i = 0; i < mw; i++) begin
                if (i == rst_at) begin
                    do_reset();
                    return;
                end
                step(1'b0, $urandom, P_M, k, 1'b0);
            end
            step(1'b1, $urandom, P_M, k, 1'(k == K_ST));
        end
        if (k == K_R || k == K_IALU || k == K_LD) step(1'($urandom), $urandom, P_W, k, 1'b1);
    endtask

    initial begin
        int sel;
        instruction  = 32'h0;
        mem_ready    = 1'b1;
        branch_taken = 1'b0;
        #3;
        check("reset_ctl",     64'(act),             64'd0);
        check("reset_phase",   64'(bus.phase),       64'd0);
        check("reset_cycle",   64'(bus.cycle_cnt),   64'd0);
        check("reset_instret", 64'(bus.instret_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        inst = 0;

        run_insn(32'h002081B3, 0, 0, -1);
        check("add_cycles",  64'(bus.cycle_cnt),   64'd4);
        check("add_instret", 64'(bus.instret_cnt), 64'd1);
        run_insn(32'h0000A103, 0, 3, -1);
        check("lw_cycles",   64'(bus.cycle_cnt),   64'd12);
        check("lw_instret",  64'(bus.instret_cnt), 64'd2);
        run_insn(32'h00208463, 0, 0, -1);
        check("beq_cycles",  64'(bus.cycle_cnt),   64'd15);
        check("beq_instret", 64'(bus.instret_cnt), 64'd3);
        check("cnt4_at_15",  64'(bus4.cycle_cnt),  64'd15);
        run_insn(32'hFFFFFFFF, 0, 0, -1);
`ifdef CU_ILLEGAL_TRAP_EN
        check("trap_cleared", 64'(bus.illegal_insn), 64'd0);
`else
        check("ill_instret", 64'(bus.instret_cnt), 64'd3);
        check("ill_cycles",  64'(bus.cycle_cnt),   64'd17);
        check("cnt4_wrap",   64'(bus4.cycle_cnt),  64'd1);
`endif
        run_insn(32'h0020A023, 1, 5, 2);
        run_insn(32'h002081B3, 0, 0, -1);
        check("restart_cycles",  64'(bus.cycle_cnt),   64'd4);
        check("restart_instret", 64'(bus.instret_cnt), 64'd1);

        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 15);
            if (sel == 15)
                run_insn(gen_word(K_ST), $urandom_range(0, 2), 3, $urandom_range(0, 2));
            else if (sel == 14)
                run_insn(gen_word(K_ILL), $urandom_range(0, 2), 0, -1);
            else
                run_insn(gen_word(sel % 7), $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
